// File: rtl/i2s_bulk_scheduler.sv
// Round-robin bulk reader for a bank of I2S receiver FIFOs: each grant emits a tagged
// header followed by exactly BULK_OF_DATA samples from the granted channel.
module i2s_err_bit (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clear,
    output logic q
);
    // A set in the same cycle as clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= (q & ~clear) | set;
    end
endmodule

module i2s_bulk_scheduler #(
    parameter int CHANNEL_NUM  = 16,
    parameter int ID_WIDTH     = 5,
    parameter int BULK_OF_DATA = 87,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNEL_NUM-1:0]            channel_enable,
    input  logic [CHANNEL_NUM-1:0]            r_ready,
    input  logic [CHANNEL_NUM-1:0]            error_full,
    input  logic [CHANNEL_NUM-1:0]            error_empty,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] rdata,
    output logic [CHANNEL_NUM-1:0]            r_enable,
    input  logic                              out_almost_full,
    output logic                              out_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              busy,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic [CHANNEL_NUM-1:0]            error_sticky,
    input  logic                              clear_errors
);
    localparam logic [1:0] SCAN   = 2'd0;
    localparam logic [1:0] HEADER = 2'd1;
    localparam logic [1:0] READ   = 2'd2;

    logic [1:0]                 state;
    logic [ID_WIDTH-1:0]        rr_ptr;
    logic [ID_WIDTH-1:0]        winner;
    logic [ID_WIDTH-1:0]        rd_id;
    logic                       found;
    logic                       rd_vld;
    logic [7:0]                 seq;
    logic [7:0]                 cnt;
    logic [CHANNEL_NUM-1:0]     cand;
    logic [CHANNEL_NUM-1:0]     rot;
    logic [2*CHANNEL_NUM-1:0]   dbl;
    int                         off;

    assign cand = channel_enable & r_ready;
    assign busy = (state != SCAN);

    // Rotate candidates so bit 0 is the channel right after rr_ptr; lowest set bit wins.
    always_comb begin
        dbl    = {cand, cand} >> (int'(rr_ptr) + 1);
        rot    = dbl[CHANNEL_NUM-1:0];
        winner = '0;
        found  = 1'b0;
        off    = 0;
        for (int k = CHANNEL_NUM - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = int'(rr_ptr) + 1 + k;
                if (off >= CHANNEL_NUM) off = off - CHANNEL_NUM;
                winner = ID_WIDTH'(off);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            grant_id <= '0;
            rr_ptr   <= ID_WIDTH'(CHANNEL_NUM - 1);
            seq      <= '0;
            cnt      <= '0;
            r_enable <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (found && !out_almost_full) begin
                        grant_id <= winner;
                        rr_ptr   <= winner;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    seq      <= seq + 8'd1;
                    cnt      <= '0;
                    r_enable <= CHANNEL_NUM'(1) << grant_id;
                    state    <= READ;
                end
                READ: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(BULK_OF_DATA - 1)) begin
                        r_enable <= '0;
                        state    <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // FIFO data lags its strobe by one cycle; rd_id keeps the slice aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld    <= 1'b0;
            rd_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            rd_vld <= |r_enable;
            rd_id  <= grant_id;
            if (state == HEADER) begin
                out_valid <= 1'b1;
                out_data  <= {8'hA5, seq, 8'(grant_id), 8'(BULK_OF_DATA)};
            end else if (rd_vld) begin
                out_valid <= 1'b1;
                out_data  <= rdata[int'(rd_id)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    i2s_err_bit u_err [CHANNEL_NUM-1:0] (
        .clk   (clk),
        .rst   (rst),
        .set   (error_full | error_empty),
        .clear (clear_errors),
        .q     (error_sticky)
    );
endmodule

// File: tb/tb_i2s_bulk_scheduler.sv
// Bench for i2s_bulk_scheduler: random FIFO contents and masks checked against a
// round-robin reference model of grants, headers, strobes and output timing.
module tb_i2s_bulk_scheduler;
    localparam int N = 16, IDW = 5, B = 4, DW = 32, DEPTH = 2048;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] channel_enable, r_ready, error_full, error_empty, r_enable, error_sticky;
    logic [N*DW-1:0] rdata;
    logic out_almost_full, out_valid, busy, clear_errors;
    logic [DW-1:0] out_data;
    logic [IDW-1:0] grant_id;

    i2s_bulk_scheduler #(.CHANNEL_NUM(N), .ID_WIDTH(IDW), .BULK_OF_DATA(B), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .channel_enable(channel_enable), .r_ready(r_ready),
        .error_full(error_full), .error_empty(error_empty), .rdata(rdata), .r_enable(r_enable),
        .out_almost_full(out_almost_full), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .grant_id(grant_id), .error_sticky(error_sticky), .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    int multi_hot = 0;
    logic [DW-1:0] mem [N][DEPTH];
    int ptr [N] = '{default: 0};
    logic [DW-1:0] obs_d[$];
    int obs_t[$];
    logic [N-1:0] ren_v[$];
    int ren_t[$];
    int m_last, m_seq;
    int mptr [N];

    // Channel FIFOs: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (r_enable[i]) begin
                rdata[i*DW +: DW] <= mem[i][ptr[i]];
                ptr[i] <= (ptr[i] + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin obs_d.push_back(out_data); obs_t.push_back(cyc); end
        if (r_enable != '0) begin ren_v.push_back(r_enable); ren_t.push_back(cyc); end
        if ($countones(r_enable) > 1) multi_hot <= multi_hot + 1;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int next_grant(input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++)
            if (mask[(m_last + i) % N]) return (m_last + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_seq  = 0;
        for (int i = 0; i < N; i++) mptr[i] = ptr[i];
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic check_bulks(input int ob, input int rb, input int k, input logic [N-1:0] mask);
        for (int b = 0; b < k; b++) begin
            int ch, h;
            ch = next_grant(mask);
            if (ch < 0) begin chk("grant_exists", 0, 1); break; end
            h = ob + b*(B+1);
            chk($sformatf("header%0d", b), obs_d[h], {8'hA5, 8'(m_seq), 8'(ch), 8'(B)});
            if (b > 0) chk("bulk_period", obs_t[h] - obs_t[h-(B+1)], B+2);
            chk("first_strobe_time", ren_t[rb+b*B], obs_t[h]);
            for (int j = 0; j < B; j++) begin
                chk("data_word", obs_d[h+1+j], mem[ch][(mptr[ch]+j) % DEPTH]);
                chk("data_time", obs_t[h+1+j] - obs_t[h], 2 + j);
                chk("strobe", ren_v[rb+b*B+j], N'(1) << ch);
            end
            mptr[ch] = (mptr[ch] + B) % DEPTH;
            m_seq    = (m_seq + 1) % 256;
            m_last   = ch;
        end
    endtask

    task automatic run_bulks(input int n, input logic [N-1:0] en, input logic [N-1:0] rdy);
        int ob, rb, k, w;
        ob = obs_d.size();
        rb = ren_v.size();
        channel_enable = en;
        r_ready = rdy;
        w = 0;
        while (obs_d.size() - ob < n*(B+1) && w < n*(B+2) + 20) begin
            @(posedge clk); #1; w++;
        end
        r_ready = '0;
        repeat (2*B + 6) @(posedge clk);
        #1;
        k = (obs_d.size() - ob) / (B+1);
        chk("bulk_count", k >= n, 1);
        chk("whole_bulks", (obs_d.size() - ob) % (B+1), 0);
        chk("strobe_count", ren_v.size() - rb, k*B);
        check_bulks(ob, rb, k, en & rdy);
        chk("grant_id", grant_id, m_last);
    endtask

    initial begin
        int ob, rb, s, w;
        logic [N-1:0] en, rdy, ef, ee, exp_err;
        for (int i = 0; i < N; i++)
            for (int d = 0; d < DEPTH; d++) mem[i][d] = $urandom;
        rst = 1'b1; channel_enable = '0; r_ready = '0; error_full = '0; error_empty = '0;
        out_almost_full = 1'b0; clear_errors = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r_enable", r_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_error_sticky", error_sticky, 0);
        rst = 1'b0;
        model_reset();

        run_bulks(1, '1, 16'h0008);
        reset_dut();
        run_bulks(17, '1, '1);
        run_bulks(8, 16'h00F0, '1);

        // Almost-full holds off the start of a bulk but never cuts one short.
        reset_dut();
        ob = obs_d.size(); rb = ren_v.size();
        out_almost_full = 1'b1; channel_enable = '1; r_ready = 16'h0001;
        repeat (10) @(posedge clk);
        #1;
        chk("af_no_header", obs_d.size() - ob, 0);
        chk("af_busy", busy, 0);
        out_almost_full = 1'b0;
        s = cyc;
        w = 0;
        while (obs_d.size() == ob && w < 10) begin @(posedge clk); #1; w++; end
        chk("af_header_time", obs_t[ob], s + 2);
        out_almost_full = 1'b1; r_ready = '0;
        repeat (2*B + 6) @(posedge clk);
        #1;
        chk("af_words", obs_d.size() - ob, B + 1);
        check_bulks(ob, rb, 1, 16'h0001);
        out_almost_full = 1'b0;

        // Reset at the second strobe aborts the bulk immediately.
        reset_dut();
        channel_enable = '1; r_ready = 16'h0020;
        w = 0;
        while (r_enable == '0 && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk);
        #1;
        chk("second_strobe", r_enable, 16'h0020);
        rst = 1'b1;
        #1;
        chk("rst_mid_r_enable", r_enable, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        ob = obs_d.size(); rb = ren_v.size();
        r_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_quiet", (obs_d.size() - ob) + (ren_v.size() - rb), 0);
        rst = 1'b0;
        model_reset();
        run_bulks(2, '1, '1);

        reset_dut();
        run_bulks(257, 16'h0100, '1);

        for (int r = 0; r < 4; r++) begin
            en  = N'($urandom);
            rdy = N'($urandom);
            if ((en & rdy) == '0) begin en[r*3] = 1'b1; rdy[r*3] = 1'b1; end
            run_bulks(int'($urandom_range(3, 8)), en, rdy);
        end

        error_empty = 16'h0004;
        @(posedge clk);
        #1 error_empty = '0;
        chk("err_set", error_sticky, 16'h0004);
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold", error_sticky, 16'h0004);
        clear_errors = 1'b1;
        @(posedge clk);
        #1 clear_errors = 1'b0;
        chk("err_clear", error_sticky, 0);
        error_full = 16'h0200; clear_errors = 1'b1;
        @(posedge clk);
        #1 error_full = '0; clear_errors = 1'b0;
        chk("err_set_wins", error_sticky, 16'h0200);
        exp_err = 16'h0200;
        for (int r = 0; r < 3; r++) begin
            ef = N'($urandom) & N'($urandom);
            ee = N'($urandom) & N'($urandom);
            error_full = ef; error_empty = ee;
            @(posedge clk);
            #1 error_full = '0; error_empty = '0;
            exp_err = exp_err | ef | ee;
            chk("err_accumulate", error_sticky, exp_err);
        end
        clear_errors = 1'b1;
        @(posedge clk);
        #1 clear_errors = 1'b0;
        chk("err_clear2", error_sticky, 0);

        chk("one_hot_strobe", multi_hot, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
